dmem_bytelane_ctrl: RTL and testbench

//  Parametrised data memory for the pipeline MEM stage; supersedes the word-only data memory.

---
 rtl/dmem_bytelane_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_bytelane_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane_ctrl.sv
// Byte-addressed data memory for the MEM stage: LB/LH/LW(U) loads, SB/SH/SW stores,
// alignment/range checking, post-reset init sweep and a fixed-latency response pipeline.
module dmem_bytelane_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] INIT_VALUE  = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t          state;
  logic [AW-1:0]   init_ptr;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            acc_err;
  logic [AW-1:0]   word_idx;
  logic [1:0]      lane_off;
  logic [3:0]      wmask;
  logic [31:0]     wdata_rep;
  logic [31:0]     load_val;

  logic            vld_p   [READ_LAT];
  logic [31:0]     rdata_p [READ_LAT];
  logic            err_p   [READ_LAT];

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (size)
      2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[AW+1:2];
  assign lane_off = req_addr[1:0];

  assign acc_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (|req_addr[31:AW+2]);

  assign wmask = lane_mask(req_size, lane_off);

  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign load_val = load_extract(mem[word_idx], lane_off, req_size, req_unsigned);

  // Control FSM: init sweep, then accept forever without backpressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_INIT;
      init_ptr  <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + AW'(1);
          if (&init_ptr) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array: init sweep has priority; stores only touch enabled lanes
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_ptr] <= INIT_VALUE;
    end else if (accept && req_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Response stage 0 captures the access at the accept edge; later stages just delay it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_p[i]   <= 1'b0;
        rdata_p[i] <= '0;
        err_p[i]   <= 1'b0;
      end
    end else begin
      vld_p[0]   <= accept;
      err_p[0]   <= accept & acc_err;
      rdata_p[0] <= (accept && !req_we && !acc_err) ? load_val : 32'h0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        rdata_p[i] <= rdata_p[i-1];
        err_p[i]   <= err_p[i-1];
      end
    end
  end

  assign rsp_valid = vld_p[READ_LAT-1];
  assign rsp_rdata = rdata_p[READ_LAT-1];
  assign rsp_err   = err_p[READ_LAT-1];

endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Bench for dmem_bytelane_ctrl: READ_LAT=1 and READ_LAT=3 instances driven in lockstep,
// directed vector table plus random traffic against a byte-array reference model.
module tb_dmem_bytelane_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rdy1, rdy3, v1, v3, e1, e3, b1, b3;
  logic [31:0] d1, d3;

  always #5 clk = ~clk;

  dmem_bytelane_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(1), .INIT_VALUE(32'h0)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1), .busy(b1));

  dmem_bytelane_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(3), .INIT_VALUE(32'h0)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3), .busy(b3));

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int rem = DEPTH;

  always @(posedge clk) edges <= edges + 1;

  // Expected readiness: DEPTH rising edges after reset release
  always @(posedge clk or negedge rstn) begin
    if (!rstn) rem <= DEPTH;
    else if (rem != 0) rem <= rem - 1;
  end

  typedef struct { int due; logic [31:0] rd; logic err; } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] size; logic uns; logic [31:0] wdata;
    logic [31:0] rd; logic err;
  } vec_t;
  vec_t tbl[$];

  logic [7:0] ref_mem [DEPTH*4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    n  = 1 << sz;
    er = (sz == 2'b11) || (a >= 32'(DEPTH*4)) || ((a % n) != 0);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[a+i]) << (8*i));
        if (!u && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 1);
      end
    end
  endtask

  task automatic mon_port(input int lat, input logic v, input logic [31:0] rd, input logic er);
    exp_t f;
    bit has;
    has = 0;
    if (lat == 1) begin
      if (q1.size() > 0) begin has = 1; f = q1[0]; end
    end else begin
      if (q3.size() > 0) begin has = 1; f = q3[0]; end
    end
    if (has && f.due == edges) begin
      check($sformatf("L%0d rsp_valid", lat), 32'(v), 32'd1);
      check($sformatf("L%0d rsp_rdata", lat), rd, f.rd);
      check($sformatf("L%0d rsp_err", lat), 32'(er), 32'(f.err));
      if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
    end else if (v) begin
      check($sformatf("L%0d spurious rsp_valid", lat), 32'(v), 32'd0);
    end
  endtask

  task automatic monitor();
    check("L1 req_ready", 32'(rdy1), 32'(rem == 0));
    check("L3 req_ready", 32'(rdy3), 32'(rem == 0));
    check("L1 busy", 32'(b1), 32'(rem != 0));
    check("L3 busy", 32'(b3), 32'(rem != 0));
    mon_port(1, v1, d1, e1);
    mon_port(3, v3, d3, e3);
  endtask

  // One clock: check outputs at the falling edge, then present the next request
  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input bit use_exp, input logic [31:0] xrd, input logic xer);
    logic [31:0] mrd;
    logic        mer;
    exp_t        e;
    @(negedge clk);
    monitor();
    req_valid = v; req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    if (v && rem == 0 && rstn) begin
      model(we, a, sz, u, wd, mrd, mer);
      e.rd  = use_exp ? xrd : mrd;
      e.err = use_exp ? xer : mer;
      e.due = edges + 1; q1.push_back(e);
      e.due = edges + 3; q3.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reset pulse, then loads hammered during init (must be ignored) while counting busy cycles
  task automatic pulse_reset(input int cyc);
    int n;
    rstn = 1'b0;
    req_valid = 1'b0;
    q1.delete();
    q3.delete();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    repeat (cyc) idle();
    rstn = 1'b1;
    n = 0;
    do begin
      drive(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      n++;
    end while (b1 && n < 2*DEPTH);
    check("init busy cycles", 32'(n), 32'(DEPTH));
  endtask

  function automatic void add(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic u, input logic [31:0] wd, input logic [31:0] rd,
                              input logic er);
    vec_t t;
    t.we = we; t.addr = a; t.size = sz; t.uns = u; t.wdata = wd; t.rd = rd; t.err = er;
    tbl.push_back(t);
  endfunction

  initial begin
    add(0, 32'h000, 2, 0, 0, 32'h00000000, 0);
    add(0, 32'hFFC, 2, 0, 0, 32'h00000000, 0);
    add(1, 32'h010, 2, 0, 32'h80FF7F01, 32'h0, 0);
    add(0, 32'h010, 0, 0, 0, 32'h00000001, 0);
    add(0, 32'h011, 0, 0, 0, 32'h0000007F, 0);
    add(0, 32'h012, 0, 0, 0, 32'hFFFFFFFF, 0);
    add(0, 32'h013, 0, 0, 0, 32'hFFFFFF80, 0);
    add(0, 32'h010, 0, 1, 0, 32'h00000001, 0);
    add(0, 32'h011, 0, 1, 0, 32'h0000007F, 0);
    add(0, 32'h012, 0, 1, 0, 32'h000000FF, 0);
    add(0, 32'h013, 0, 1, 0, 32'h00000080, 0);
    add(0, 32'h010, 1, 0, 0, 32'h00007F01, 0);
    add(0, 32'h012, 1, 0, 0, 32'hFFFF80FF, 0);
    add(0, 32'h010, 1, 1, 0, 32'h00007F01, 0);
    add(0, 32'h012, 1, 1, 0, 32'h000080FF, 0);
    add(1, 32'h020, 2, 0, 32'hAAAAAAAA, 32'h0, 0);
    add(1, 32'h021, 0, 0, 32'hFFFFFF55, 32'h0, 0);
    add(1, 32'h022, 1, 0, 32'hFFFF1234, 32'h0, 0);
    add(0, 32'h020, 2, 0, 0, 32'h123455AA, 0);
    add(0, 32'h001, 1, 0, 0, 32'h0, 1);
    add(0, 32'h002, 2, 0, 0, 32'h0, 1);
    add(1, 32'h006, 2, 0, 32'hDEADBEEF, 32'h0, 1);
    add(0, 32'h008, 3, 0, 0, 32'h0, 1);
    add(0, 32'h1000, 2, 0, 0, 32'h0, 1);
    add(0, 32'h004, 2, 0, 0, 32'h00000000, 0);
    add(1, 32'h040, 2, 0, 32'h11, 32'h0, 0);
    add(0, 32'h040, 2, 0, 0, 32'h00000011, 0);
    add(1, 32'h040, 2, 0, 32'h22, 32'h0, 0);
    add(0, 32'h040, 2, 0, 0, 32'h00000022, 0);

    // Outputs while held in reset
    @(negedge clk);
    check("reset L1 req_ready", 32'(rdy1), 32'd0);
    check("reset L1 rsp_valid", 32'(v1), 32'd0);
    check("reset L1 rsp_rdata", d1, 32'd0);
    check("reset L1 rsp_err", 32'(e1), 32'd0);
    check("reset L1 busy", 32'(b1), 32'd1);
    check("reset L3 req_ready", 32'(rdy3), 32'd0);
    check("reset L3 rsp_valid", 32'(v3), 32'd0);
    check("reset L3 busy", 32'(b3), 32'd1);

    pulse_reset(1);

    // Directed vectors, issued back to back
    foreach (tbl[i])
      drive(1'b1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata,
            1'b1, tbl[i].rd, tbl[i].err);
    repeat (4) idle();

    // Random traffic, mostly on a small window so stores and loads collide
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'hFF0 + $urandom_range(0, 31);
        default: a = $urandom_range(0, 127);
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, sz,
            1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0, 1'b0);
    end
    repeat (4) idle();

    // Two loads in flight when reset hits: no responses may appear for them
    drive(1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle();
    rstn = 1'b0;
    req_valid = 1'b0;
    q1.delete();
    q3.delete();
    idle();
    rstn = 1'b1;
    repeat (500) idle();
    check("mid-init busy", 32'(b1), 32'd1);
    pulse_reset(2);

    drive(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    repeat (5) idle();
    check("responses drained", 32'(q1.size() + q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
